// File: rtl/lpwb_pkg.sv
// Shared parameters and write-port source encoding for the long-pipe writeback controller.
// Optional same-cycle completion forwarding is enabled by defining LPWB_BYPASS_EN.
package lpwb_pkg;

    localparam int LPWB_DEPTH = 4;
    localparam int LPWB_AW    = 2;
    localparam int LPWB_XLEN  = 64;
    localparam int LPWB_RAW   = 5;

    // Which source feeds the register-file write port this cycle.
    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_SLOT = 2'd1,
        WR_CMP0 = 2'd2,
        WR_CMP1 = 2'd3
    } wr_src_e;

endpackage

// File: rtl/lpwb_entry.sv
// One writeback slot: valid/done flags, destination register and captured result.
module lpwb_entry
    import lpwb_pkg::*;
#(
    parameter int XLEN = LPWB_XLEN,
    parameter int RAW  = LPWB_RAW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [RAW-1:0]  alloc_rd,
    input  logic            set,
    input  logic [XLEN-1:0] set_data,
    input  logic            clr,
    output logic            vld,
    output logic            done,
    output logic [RAW-1:0]  rd,
    output logic [XLEN-1:0] data
);

    // Slot state; allocation and retirement never target the same slot in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            done <= 1'b0;
            rd   <= {RAW{1'b0}};
            data <= {XLEN{1'b0}};
        end else if (alloc) begin
            vld  <= 1'b1;
            done <= 1'b0;
            rd   <= alloc_rd;
        end else if (clr) begin
            vld  <= 1'b0;
            done <= 1'b0;
        end else if (set) begin
            done <= 1'b1;
            data <= set_data;
        end
    end

endmodule

// File: rtl/lpwb_ctrl.sv
// Long-pipe writeback controller: in-order retirement of out-of-order completions.
// Define LPWB_BYPASS_EN to forward a completion that hits the waiting head straight to the write port.
module lpwb_ctrl
    import lpwb_pkg::*;
#(
    parameter int DEPTH = LPWB_DEPTH,
    parameter int AW    = LPWB_AW,
    parameter int XLEN  = LPWB_XLEN,
    parameter int RAW   = LPWB_RAW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            disp_en,
    input  logic [RAW-1:0]  disp_rd,
    output logic [AW-1:0]   disp_itag,
    output logic            lpwb_full,
    output logic            lpwb_empty,
    input  logic            cmp0_valid,
    output logic            cmp0_ready,
    input  logic [AW-1:0]   cmp0_itag,
    input  logic [XLEN-1:0] cmp0_wdata,
    input  logic            cmp1_valid,
    output logic            cmp1_ready,
    input  logic [AW-1:0]   cmp1_itag,
    input  logic [XLEN-1:0] cmp1_wdata,
    output logic            rf_wen,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_wready,
    output logic            wb_en
);

    logic [AW:0]     wptr_r, rptr_r;
    logic [AW-1:0]   head_s;
    logic            disp_fire_s;
    logic            byp_ret_s;
    logic            head_live_s;
    wr_src_e         src_s;
    logic [XLEN-1:0] sel_data_s;
    logic [DEPTH-1:0] vld_s, done_s, alloc_s, set_s, clr_s;
    logic [RAW-1:0]  rd_s [DEPTH];
    logic [XLEN-1:0] data_s [DEPTH];
    logic [XLEN-1:0] set_data_s [DEPTH];

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign head_s      = rptr_r[AW-1:0];
    assign disp_itag   = wptr_r[AW-1:0];
    assign lpwb_empty  = (wptr_r == rptr_r);
    assign lpwb_full   = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
    assign disp_fire_s = disp_en && !lpwb_full;

    assign cmp0_ready = cmp0_valid && vld_s[cmp0_itag] && !done_s[cmp0_itag];
    assign cmp1_ready = cmp1_valid && vld_s[cmp1_itag] && !done_s[cmp1_itag]
                        && !(cmp0_ready && (cmp0_itag == cmp1_itag));

    // Select the write-port source: a completed head, or a completion hitting the head.
    always_comb begin
        src_s = WR_NONE;
        if (vld_s[head_s] && done_s[head_s]) begin
            src_s = WR_SLOT;
        end
`ifdef LPWB_BYPASS_EN
        else if (cmp0_ready && (cmp0_itag == head_s)) begin
            src_s = WR_CMP0;
        end else if (cmp1_ready && (cmp1_itag == head_s)) begin
            src_s = WR_CMP1;
        end
`endif
        else begin
            src_s = WR_NONE;
        end
    end

    // Write-port drive; address and data read as zero whenever no write is requested.
    always_comb begin
        case (src_s)
            WR_SLOT: sel_data_s = data_s[head_s];
            WR_CMP0: sel_data_s = cmp0_wdata;
            WR_CMP1: sel_data_s = cmp1_wdata;
            default: sel_data_s = {XLEN{1'b0}};
        endcase
        head_live_s = (src_s != WR_NONE);
        rf_wen      = head_live_s && (rd_s[head_s] != {RAW{1'b0}});
        if (rf_wen) begin
            rf_waddr = rd_s[head_s];
            rf_wdata = sel_data_s;
        end else begin
            rf_waddr = {RAW{1'b0}};
            rf_wdata = {XLEN{1'b0}};
        end
        wb_en     = head_live_s && ((rd_s[head_s] == {RAW{1'b0}}) || rf_wready);
        byp_ret_s = wb_en && ((src_s == WR_CMP0) || (src_s == WR_CMP1));
    end

    // Per-slot allocate / complete / retire enables; a forwarded retire never marks done.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            alloc_s[i] = disp_fire_s && (wptr_r[AW-1:0] == AW'(i));
            clr_s[i]   = wb_en && (head_s == AW'(i));
            set_s[i]   = ((cmp0_ready && (cmp0_itag == AW'(i))) ||
                          (cmp1_ready && (cmp1_itag == AW'(i))))
                         && !(byp_ret_s && (head_s == AW'(i)));
            if (cmp0_ready && (cmp0_itag == AW'(i))) begin
                set_data_s[i] = cmp0_wdata;
            end else begin
                set_data_s[i] = cmp1_wdata;
            end
        end
    end

    // Write and read pointers; the top bit toggles naturally on wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (disp_fire_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (wb_en) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        lpwb_entry #(
            .XLEN(XLEN),
            .RAW (RAW)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .alloc   (alloc_s[g]),
            .alloc_rd(disp_rd),
            .set     (set_s[g]),
            .set_data(set_data_s[g]),
            .clr     (clr_s[g]),
            .vld     (vld_s[g]),
            .done    (done_s[g]),
            .rd      (rd_s[g]),
            .data    (data_s[g])
        );
    end

endmodule

// File: tb/tb_lpwb_ctrl.sv
// Scoreboard bench for lpwb_ctrl: an in-order queue model predicts every cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_lpwb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_en = 1'b0;
    logic [4:0]  disp_rd = 5'd0;
    logic [1:0]  disp_itag;
    logic        lpwb_full, lpwb_empty;
    logic        cmp0_valid = 1'b0, cmp1_valid = 1'b0;
    logic        cmp0_ready, cmp1_ready;
    logic [1:0]  cmp0_itag = 2'd0, cmp1_itag = 2'd0;
    logic [63:0] cmp0_wdata = 64'd0, cmp1_wdata = 64'd0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_wready = 1'b0;
    logic        wb_en;

    lpwb_ctrl dut (
        .clk(clk), .rst(rst),
        .disp_en(disp_en), .disp_rd(disp_rd), .disp_itag(disp_itag),
        .lpwb_full(lpwb_full), .lpwb_empty(lpwb_empty),
        .cmp0_valid(cmp0_valid), .cmp0_ready(cmp0_ready),
        .cmp0_itag(cmp0_itag), .cmp0_wdata(cmp0_wdata),
        .cmp1_valid(cmp1_valid), .cmp1_ready(cmp1_ready),
        .cmp1_itag(cmp1_itag), .cmp1_wdata(cmp1_wdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wready(rf_wready), .wb_en(wb_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  itag;
        logic [4:0]  rd;
        bit          done;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        bit          r0, r1, full, empty, wen, wb;
        logic [1:0]  itag;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } exp_t;

    ent_t pend[$];
    exp_t exp_q[$];
    int   nxt = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmp0_ready", 64'(cmp0_ready), 64'(e.r0));
            chk("cmp1_ready", 64'(cmp1_ready), 64'(e.r1));
            chk("lpwb_full",  64'(lpwb_full),  64'(e.full));
            chk("lpwb_empty", 64'(lpwb_empty), 64'(e.empty));
            chk("disp_itag",  64'(disp_itag),  64'(e.itag));
            chk("rf_wen",     64'(rf_wen),     64'(e.wen));
            chk("rf_waddr",   64'(rf_waddr),   64'(e.waddr));
            chk("rf_wdata",   rf_wdata,        e.wdata);
            chk("wb_en",      64'(wb_en),      64'(e.wb));
        end
    end

    function automatic int find(input logic [1:0] t);
        foreach (pend[k]) if (pend[k].itag == t) return k;
        return -1;
    endfunction

    // One cycle: drive inputs, predict outputs from the model, advance the model.
    task automatic cyc(input bit de, input logic [4:0] rd,
                       input bit v0, input logic [1:0] t0, input logic [63:0] d0,
                       input bit v1, input logic [1:0] t1, input logic [63:0] d1,
                       input bit wr);
        exp_t e;
        ent_t n;
        int   i0, i1;
        bit   byp = 0;
        disp_en = de; disp_rd = rd;
        cmp0_valid = v0; cmp0_itag = t0; cmp0_wdata = d0;
        cmp1_valid = v1; cmp1_itag = t1; cmp1_wdata = d1;
        rf_wready = wr;
        e = '{default: '0};
        e.full  = (pend.size() == DEPTH);
        e.empty = (pend.size() == 0);
        e.itag  = 2'(nxt % DEPTH);
        i0 = find(t0);
        i1 = find(t1);
        e.r0 = v0 && (i0 >= 0) && !pend[i0].done;
        e.r1 = v1 && (i1 >= 0) && !pend[i1].done && !(e.r0 && (t1 == t0));
        if (pend.size() > 0 && pend[0].done) begin
            e.wen = (pend[0].rd != 5'd0);
            e.waddr = pend[0].rd;
            e.wdata = pend[0].data;
            e.wb = (pend[0].rd == 5'd0) || wr;
        end
`ifdef LPWB_BYPASS_EN
        else if (pend.size() > 0 && ((e.r0 && i0 == 0) || (e.r1 && i1 == 0))) begin
            e.wen = (pend[0].rd != 5'd0);
            e.waddr = pend[0].rd;
            e.wdata = (e.r0 && i0 == 0) ? d0 : d1;
            e.wb = (pend[0].rd == 5'd0) || wr;
            byp = e.wb;
        end
`endif
        if (!e.wen) begin
            e.waddr = 5'd0;
            e.wdata = 64'd0;
        end
        exp_q.push_back(e);
        if (e.r0 && !(byp && i0 == 0)) begin
            n = pend[i0]; n.done = 1; n.data = d0; pend[i0] = n;
        end
        if (e.r1 && !(byp && i1 == 0)) begin
            n = pend[i1]; n.done = 1; n.data = d1; pend[i1] = n;
        end
        if (e.wb) void'(pend.pop_front());
        if (de && !e.full) begin
            n.itag = 2'(nxt % DEPTH); n.rd = rd; n.done = 0; n.data = 64'd0;
            pend.push_back(n);
            nxt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit wr);
        for (int k = 0; k < n; k++) cyc(0, 5'd0, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, wr);
    endtask

    // Reset for two cycles; a completion offered meanwhile must be held off.
    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        pend.delete();
        nxt = 0;
        for (int k = 0; k < 2; k++) begin
            disp_en = 1'b1; disp_rd = 5'd9;
            cmp0_valid = 1'b1; cmp0_itag = 2'(k); cmp0_wdata = 64'h55;
            cmp1_valid = 1'b0; rf_wready = 1'b1;
            e = '{default: '0};
            e.empty = 1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    function automatic logic [1:0] pick_itag();
        if (pend.size() > 0 && $urandom_range(0, 9) < 8)
            return pend[$urandom_range(0, pend.size() - 1)].itag;
        return 2'($urandom_range(0, 3));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // in-order write
        cyc(1, 5'd5, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(1, 5'd6, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 1, 2'd0, 64'h11, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 1, 2'd1, 64'h22, 0, 2'd0, 64'd0, 1);
        idle(3, 1);
        // out-of-order completion
        do_reset();
        cyc(1, 5'd3, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(1, 5'd4, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 1, 2'd1, 64'hBB, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 0, 2'd0, 64'd0, 1, 2'd0, 64'hAA, 1);
        idle(3, 1);
        // full, ignored dispatch, retire+dispatch refused, wrap
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(1, 5'(k), 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(1, 5'd9, 1, 2'd0, 64'hA0, 0, 2'd0, 64'd0, 1);
        cyc(1, 5'd9, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(1, 5'd10, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 1, 2'd1, 64'hA1, 1, 2'd2, 64'hA2, 1);
        cyc(0, 5'd0, 1, 2'd3, 64'hA3, 1, 2'd0, 64'hA4, 1);
        idle(5, 1);
        // simultaneous completions
        do_reset();
        for (int k = 10; k < 14; k++) cyc(1, 5'(k), 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 0);
        cyc(0, 5'd0, 1, 2'd2, 64'hC2, 1, 2'd2, 64'hD2, 0);
        cyc(0, 5'd0, 1, 2'd1, 64'hC1, 1, 2'd3, 64'hD3, 0);
        cyc(0, 5'd0, 0, 2'd0, 64'd0, 1, 2'd0, 64'hD0, 1);
        idle(5, 1);
        // x0 retire and back-pressure
        do_reset();
        cyc(1, 5'd0, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 0);
        cyc(1, 5'd7, 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 0);
        cyc(0, 5'd0, 1, 2'd0, 64'hE0, 1, 2'd1, 64'hE7, 0);
        idle(4, 0);
        idle(2, 1);
        // reset mid-flight, stale completion, head completion (bypass when enabled)
        for (int k = 0; k < 3; k++) cyc(1, 5'(20 + k), 0, 2'd0, 64'd0, 0, 2'd0, 64'd0, 1);
        do_reset();
        cyc(1, 5'd9, 1, 2'd1, 64'hF1, 0, 2'd0, 64'd0, 1);
        cyc(0, 5'd0, 1, 2'd0, 64'hF0, 0, 2'd0, 64'd0, 1);
        idle(2, 1);
        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            logic [4:0] r;
            r = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            cyc($urandom_range(0, 9) < 6, r,
                $urandom_range(0, 9) < 5, pick_itag(), {$urandom, $urandom},
                $urandom_range(0, 9) < 4, pick_itag(), {$urandom, $urandom},
                $urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle(1, 1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
